action_issue: RTL and testbench

Stage-local action issuer that drives the action engine of the same stage. It takes each PHV together with its match result, fetches the matching VLIW action word from a writable action table, and emits the PHV and action word aligned on the same cycle. A per-stage default action covers misses. A sequenced table-clear FSM and hit/miss statistics support control-plane use.

---
 rtl/action_issue.sv | 225 ++++++++++++++++++++++
 tb/tb_action_issue.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_issue.sv
// action_issue: per-stage action issuer.
// Looks up a VLIW action word for each incoming PHV in a writable action
// table, substitutes a default action on misses, and presents the PHV and
// its action word together two cycles after the lookup. A sequenced clear
// walks the table one entry per cycle. Saturating counters track how many
// hits and misses were issued.
module action_issue #(
  parameter int STAGE_ID = 0,
  parameter int PHV_LEN  = 1124,
  parameter int ACT_LEN  = 25,
  parameter int ACT_NUM  = 25,
  parameter int ADDR_W   = 4,
  localparam int AW      = ACT_LEN * ACT_NUM
) (
  input  logic               clk,
  input  logic               rst,
  // lookup request
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  input  logic               match_hit,
  input  logic [ADDR_W-1:0]  match_addr,
  // control-plane configuration
  input  logic               cfg_wr_en,
  input  logic [ADDR_W-1:0]  cfg_wr_addr,
  input  logic [AW-1:0]      cfg_wr_data,
  input  logic               cfg_def_wr_en,
  input  logic               cfg_clear,
  output logic               cfg_busy,
  output logic               cfg_clear_done,
  // issue to the action engine
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_valid_out,
  output logic [AW-1:0]      action_out,
  output logic               action_valid_out,
  // statistics
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  // STAGE_ID only names the stage in the hierarchy; nothing depends on it.
  if (STAGE_ID < 0) begin : g_stage_id_negative
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clr_state_e;

  clr_state_e          state_q;
  clr_state_e          state_d;
  logic [ADDR_W-1:0]   clr_ptr_q;

  logic [AW-1:0]       tbl_data [DEPTH];
  logic [DEPTH-1:0]    tbl_valid_q;
  logic [AW-1:0]       def_act_q;

  logic                clearing;
  logic                wr_accept;
  logic                fwd_entry;
  logic                entry_valid;
  logic                eff_hit;
  logic [AW-1:0]       tbl_rd;
  logic [AW-1:0]       def_rd;
  logic [AW-1:0]       act_sel;

  logic                valid_s1;
  logic                hit_s1;
  logic [PHV_LEN-1:0]  phv_s1;
  logic [AW-1:0]       act_s1;

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------

  // Clear FSM state register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value; blocking = here would make results depend on block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Clear FSM next-state: a pulse in IDLE starts the walk, the last entry
  // moves to DONE, DONE lasts exactly one cycle. Pulses outside IDLE are ignored.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_clear) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear FSM outputs: busy while walking the table, done pulse afterwards.
  always_comb begin
    cfg_busy       = 1'b0;
    cfg_clear_done = 1'b0;
    case (state_q)
      ST_CLEAR: cfg_busy       = 1'b1;
      ST_DONE:  cfg_clear_done = 1'b1;
      default:  ;
    endcase
  end

  // Clear pointer: restarts at 0 on a clear request, advances once per CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr_q <= '0;
    end else if (state_q == ST_IDLE && cfg_clear) begin
      clr_ptr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
    end
  end

  assign clearing  = (state_q == ST_CLEAR);
  // Table writes are dropped while the clear owns the table write port.
  assign wr_accept = cfg_wr_en && !clearing;

  // ---------------------------------------------------------------------
  // Action storage
  // ---------------------------------------------------------------------

  // Table entry data: the clear zeroes the pointed entry, otherwise the
  // configuration write lands.
  // NOTE: entry data carries no reset; the valid bits decide whether it is
  // ever used, so the array can map onto plain storage without a reset net.
  always_ff @(posedge clk) begin
    if (clearing) begin
      tbl_data[clr_ptr_q] <= '0;
    end else if (wr_accept) begin
      tbl_data[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Entry valid bits: cleared by reset and by the clear walk, set by writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_valid_q <= '0;
    end else if (clearing) begin
      tbl_valid_q[clr_ptr_q] <= 1'b0;
    end else if (wr_accept) begin
      tbl_valid_q[cfg_wr_addr] <= 1'b1;
    end
  end

  // Default (miss) action register; writable at any time, even mid-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                def_act_q <= '0;
    else if (cfg_def_wr_en) def_act_q <= cfg_wr_data;
  end

  // ---------------------------------------------------------------------
  // Lookup and action selection
  // ---------------------------------------------------------------------

  // A write to the looked-up address in the same cycle is forwarded, both
  // its data and its valid bit, so the lookup sees the new entry as a hit.
  assign fwd_entry   = wr_accept && (cfg_wr_addr == match_addr);
  assign entry_valid = fwd_entry || tbl_valid_q[match_addr];
  assign eff_hit     = match_hit && entry_valid && !clearing;
  assign tbl_rd      = fwd_entry     ? cfg_wr_data : tbl_data[match_addr];
  assign def_rd      = cfg_def_wr_en ? cfg_wr_data : def_act_q;
  assign act_sel     = eff_hit       ? tbl_rd      : def_rd;

  // ---------------------------------------------------------------------
  // Two-stage issue pipeline
  // ---------------------------------------------------------------------

  // Stage 1: capture the selected action together with its PHV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      hit_s1   <= 1'b0;
      phv_s1   <= '0;
      act_s1   <= '0;
    end else begin
      valid_s1 <= phv_valid_in;
      if (phv_valid_in) begin
        hit_s1 <= eff_hit;
        phv_s1 <= phv_in;
        act_s1 <= act_sel;
      end
    end
  end

  // Stage 2: issue to the action engine; data holds while nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv_valid_out <= 1'b0;
      phv_out       <= '0;
      action_out    <= '0;
    end else begin
      phv_valid_out <= valid_s1;
      if (valid_s1) begin
        phv_out    <= phv_s1;
        action_out <= act_s1;
      end
    end
  end

  assign action_valid_out = phv_valid_out;

  // Hit/miss statistics, counted on the cycle the result is issued and
  // pinned at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (valid_s1) begin
      if (hit_s1) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_action_issue.sv
// Testbench for action_issue: directed scenarios plus a randomized run,
// all checked against a cycle-level reference model of the issuer.
module tb_action_issue;

  localparam int PHV_LEN = 1124;
  localparam int ACT_LEN = 25;
  localparam int ACT_NUM = 25;
  localparam int AW      = ACT_LEN * ACT_NUM;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid_in;
  logic               match_hit;
  logic [ADDR_W-1:0]  match_addr;
  logic               cfg_wr_en;
  logic [ADDR_W-1:0]  cfg_wr_addr;
  logic [AW-1:0]      cfg_wr_data;
  logic               cfg_def_wr_en;
  logic               cfg_clear;
  logic               cfg_busy;
  logic               cfg_clear_done;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out;
  logic [AW-1:0]      action_out;
  logic               action_valid_out;
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;

  always #5 clk = ~clk;

  action_issue #(
    .STAGE_ID (0),
    .PHV_LEN  (PHV_LEN),
    .ACT_LEN  (ACT_LEN),
    .ACT_NUM  (ACT_NUM),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .phv_in           (phv_in),
    .phv_valid_in     (phv_valid_in),
    .match_hit        (match_hit),
    .match_addr       (match_addr),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_data      (cfg_wr_data),
    .cfg_def_wr_en    (cfg_def_wr_en),
    .cfg_clear        (cfg_clear),
    .cfg_busy         (cfg_busy),
    .cfg_clear_done   (cfg_clear_done),
    .phv_out          (phv_out),
    .phv_valid_out    (phv_valid_out),
    .action_out       (action_out),
    .action_valid_out (action_valid_out),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [PHV_LEN-1:0] phv;
    logic [AW-1:0]      act;
    bit                 hit;
    int                 due;
  } issue_t;

  logic [AW-1:0] m_tbl [DEPTH];
  bit            m_vld [DEPTH];
  logic [AW-1:0] m_def;
  int            m_clr_left;   // clear cycles still to run; busy while > 0
  bit            m_done;
  logic [31:0]   m_hit;
  logic [31:0]   m_miss;
  int            cyc;
  issue_t        pend [$];

  logic               exp_valid;
  logic [PHV_LEN-1:0] exp_phv;
  logic [AW-1:0]      exp_act;
  logic [3:0]         exp_st;
  logic [63:0]        exp_cnt;

  wire [3:0]  dut_st  = {phv_valid_out, action_valid_out, cfg_busy, cfg_clear_done};
  wire [63:0] dut_cnt = {hit_cnt, miss_cnt};

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [1151:0] t;
    for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom;
    return t[PHV_LEN-1:0];
  endfunction

  function automatic logic [AW-1:0] rand_act();
    logic [639:0] t;
    for (int i = 0; i < 20; i++) t[i*32 +: 32] = $urandom;
    return t[AW-1:0];
  endfunction

  // 32-bit xor fold so a PHV mismatch fits on one report line.
  function automatic logic [31:0] fold(input logic [PHV_LEN-1:0] v);
    logic [1151:0] t;
    logic [31:0]   f;
    t = '0;
    t[PHV_LEN-1:0] = v;
    f = '0;
    for (int i = 0; i < 36; i++) f = f ^ t[i*32 +: 32];
    return f;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_def      = '0;
    m_clr_left = 0;
    m_done     = 1'b0;
    m_hit      = '0;
    m_miss     = '0;
    exp_valid  = 1'b0;
    exp_phv    = '0;
    exp_act    = '0;
    exp_st     = '0;
    exp_cnt    = '0;
  endtask

  task automatic drive_idle();
    phv_in        = '0;
    phv_valid_in  = 1'b0;
    match_hit     = 1'b0;
    match_addr    = '0;
    cfg_wr_en     = 1'b0;
    cfg_wr_addr   = '0;
    cfg_wr_data   = '0;
    cfg_def_wr_en = 1'b0;
    cfg_clear     = 1'b0;
  endtask

  // Applies the currently driven inputs to the model, advances one clock,
  // and leaves the expected post-edge outputs in exp_*; returns 1 time unit
  // after the edge.
  task automatic tick();
    bit     busy;
    bit     fwd;
    bit     hit;
    bit     nd;
    int     idx;
    issue_t it;
    busy = (m_clr_left > 0);
    if (phv_valid_in) begin
      fwd    = cfg_wr_en && !busy && (cfg_wr_addr == match_addr);
      hit    = match_hit && !busy && (m_vld[match_addr] || fwd);
      it.phv = phv_in;
      it.hit = hit;
      it.due = cyc + 2;
      if (hit) it.act = fwd ? cfg_wr_data : m_tbl[match_addr];
      else     it.act = cfg_def_wr_en ? cfg_wr_data : m_def;
      pend.push_back(it);
    end
    nd = 1'b0;
    if (busy) begin
      idx        = DEPTH - m_clr_left;
      m_tbl[idx] = '0;
      m_vld[idx] = 1'b0;
      m_clr_left = m_clr_left - 1;
      nd         = (m_clr_left == 0);
    end else if (cfg_wr_en) begin
      m_tbl[cfg_wr_addr] = cfg_wr_data;
      m_vld[cfg_wr_addr] = 1'b1;
    end
    if (cfg_def_wr_en) m_def = cfg_wr_data;
    if (cfg_clear && !busy && !m_done) m_clr_left = DEPTH;
    m_done = nd;
    @(posedge clk);
    cyc++;
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      it        = pend.pop_front();
      exp_valid = 1'b1;
      exp_phv   = it.phv;
      exp_act   = it.act;
      if (it.hit) begin
        if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 32'd1;
      end else begin
        if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
      end
    end
    exp_st  = {exp_valid, exp_valid, (m_clr_left > 0), m_done};
    exp_cnt = {m_hit, m_miss};
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    model_reset();
    cyc = 0;
    #12;
    total++; if (dut_st !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b want 0000", dut_st); end
    total++; if (action_out !== '0) begin bad++; $display("FAIL reset_action: got %h want 0", action_out); end
    total++; if (phv_out !== '0) begin bad++; $display("FAIL reset_phv: got fold %h want 0", fold(phv_out)); end
    total++; if (dut_cnt !== 64'd0) begin bad++; $display("FAIL reset_counts: got %h want 0", dut_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_hit_basic();
    logic [PHV_LEN-1:0] p1;
    drive_idle(); cfg_wr_en = 1'b1; cfg_wr_addr = 4'd3; cfg_wr_data = AW'(12'h1AB);
    tick();
    drive_idle(); p1 = rand_phv(); phv_valid_in = 1'b1; phv_in = p1; match_hit = 1'b1; match_addr = 4'd3;
    tick();
    total++; if (dut_st !== 4'b0000) begin bad++; $display("FAIL hit_first_cycle: got %b want 0000", dut_st); end
    drive_idle();
    tick();
    total++; if (dut_st !== 4'b1100) begin bad++; $display("FAIL hit_valid: got %b want 1100", dut_st); end
    total++; if (action_out !== AW'(12'h1AB)) begin bad++; $display("FAIL hit_action: got %h want 1ab", action_out); end
    total++; if (phv_out !== p1) begin bad++; $display("FAIL hit_phv: got fold %h want fold %h", fold(phv_out), fold(p1)); end
    total++; if (dut_cnt !== {32'd1, 32'd0}) begin bad++; $display("FAIL hit_counts: got %h want 1/0", dut_cnt); end
    tick();
    total++; if (dut_st !== 4'b0000) begin bad++; $display("FAIL hit_valid_drop: got %b want 0000", dut_st); end
    total++; if (action_out !== AW'(12'h1AB) || phv_out !== p1) begin bad++; $display("FAIL hit_hold: got act %h phv fold %h want act 1ab phv fold %h", action_out, fold(phv_out), fold(p1)); end
  endtask

  task automatic test_default_miss();
    drive_idle(); cfg_def_wr_en = 1'b1; cfg_wr_data = AW'(4'h7);
    tick();
    drive_idle(); phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b1; match_addr = 4'd5;
    tick();
    drive_idle();
    tick();
    total++; if (dut_st !== 4'b1100) begin bad++; $display("FAIL miss_valid: got %b want 1100", dut_st); end
    total++; if (action_out !== AW'(4'h7)) begin bad++; $display("FAIL miss_default: got %h want 7", action_out); end
    total++; if (dut_cnt !== {32'd1, 32'd1}) begin bad++; $display("FAIL miss_counts: got %h want 1/1", dut_cnt); end
  endtask

  task automatic test_forwarding();
    drive_idle(); cfg_wr_en = 1'b1; cfg_wr_addr = 4'd2; cfg_wr_data = AW'(8'h11);
    tick();
    // same-cycle entry write and lookup
    drive_idle(); cfg_wr_en = 1'b1; cfg_wr_addr = 4'd2; cfg_wr_data = AW'(8'h55);
    phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b1; match_addr = 4'd2;
    tick();
    drive_idle(); cfg_wr_en = 1'b1; cfg_wr_addr = 4'd2; cfg_wr_data = AW'(8'h99);
    tick();
    total++; if (action_out !== AW'(8'h55) || dut_st !== 4'b1100) begin bad++; $display("FAIL fwd_entry: got act %h st %b want act 55 st 1100", action_out, dut_st); end
    // same-cycle default write and miss lookup
    drive_idle(); cfg_def_wr_en = 1'b1; cfg_wr_data = AW'(8'h33);
    phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b0; match_addr = 4'd2;
    tick();
    drive_idle(); cfg_def_wr_en = 1'b1; cfg_wr_data = AW'(8'h44);
    tick();
    total++; if (action_out !== AW'(8'h33)) begin bad++; $display("FAIL fwd_default: got %h want 33", action_out); end
    // same-cycle write makes a never-written entry a hit
    drive_idle(); cfg_wr_en = 1'b1; cfg_wr_addr = 4'd9; cfg_wr_data = AW'(8'h9A);
    phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b1; match_addr = 4'd9;
    tick();
    drive_idle();
    tick();
    total++; if (action_out !== AW'(8'h9A)) begin bad++; $display("FAIL fwd_valid: got %h want 9a", action_out); end
    total++; if (dut_cnt !== {32'd3, 32'd2}) begin bad++; $display("FAIL fwd_counts: got %h want 3/2", dut_cnt); end
  endtask

  task automatic test_clear();
    int          busy_n;
    int          done_n;
    logic [31:0] h0;
    logic [31:0] m0;
    busy_n = 0;
    done_n = 0;
    h0 = m_hit;
    m0 = m_miss;
    drive_idle(); cfg_clear = 1'b1;
    tick();
    if (cfg_busy === 1'b1) busy_n++;
    total++; if (dut_st !== exp_st) begin bad++; $display("FAIL clear_start: got %b want %b", dut_st, exp_st); end
    for (int i = 0; i < 20; i++) begin
      drive_idle();
      if (i == 3) begin phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b1; match_addr = 4'd3; end
      if (i == 5) begin cfg_wr_en = 1'b1; cfg_wr_addr = 4'd7; cfg_wr_data = rand_act(); end
      if (i == 8) cfg_clear = 1'b1;
      tick();
      if (cfg_busy === 1'b1) busy_n++;
      if (cfg_clear_done === 1'b1) done_n++;
      total++; if (dut_st !== exp_st) begin bad++; $display("FAIL clear_status: cycle %0d got %b want %b", i, dut_st, exp_st); end
      if (phv_valid_out === 1'b1) begin
        total++; if (action_out !== AW'(8'h44)) begin bad++; $display("FAIL clear_lookup_default: got %h want 44", action_out); end
      end
    end
    total++; if (busy_n !== DEPTH) begin bad++; $display("FAIL clear_busy_len: got %0d want %0d", busy_n, DEPTH); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL clear_done_pulses: got %0d want 1", done_n); end
    // every entry, including the one written mid-clear, now misses
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_idle();
      if (i < DEPTH) begin phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b1; match_addr = ADDR_W'(i); end
      tick();
      total++; if (dut_st !== exp_st || action_out !== exp_act) begin bad++; $display("FAIL clear_sweep: cycle %0d got st %b act %h want st %b act %h", i, dut_st, action_out, exp_st, exp_act); end
    end
    total++; if (dut_cnt !== {h0, m0 + 32'd17}) begin bad++; $display("FAIL clear_counts: got %h want %h", dut_cnt, {h0, m0 + 32'd17}); end
  endtask

  task automatic test_back_to_back();
    int          n_valid;
    int          first;
    int          last;
    logic [31:0] h0;
    logic [31:0] m0;
    for (int a = 0; a < DEPTH; a++) begin
      drive_idle(); cfg_wr_en = 1'b1; cfg_wr_addr = ADDR_W'(a); cfg_wr_data = rand_act();
      tick();
    end
    h0 = m_hit;
    m0 = m_miss;
    n_valid = 0;
    first   = -1;
    last    = -1;
    for (int i = 0; i < 22; i++) begin
      drive_idle();
      if (i < 20) begin
        phv_valid_in = 1'b1; phv_in = rand_phv();
        match_hit = (i % 2 == 0); match_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
      tick();
      if (phv_valid_out === 1'b1) begin
        n_valid++;
        if (first < 0) first = i;
        last = i;
      end
      total++; if (dut_st !== exp_st) begin bad++; $display("FAIL b2b_status: cycle %0d got %b want %b", i, dut_st, exp_st); end
      total++; if (action_out !== exp_act) begin bad++; $display("FAIL b2b_action: cycle %0d got %h want %h", i, action_out, exp_act); end
      total++; if (phv_out !== exp_phv) begin bad++; $display("FAIL b2b_phv: cycle %0d got fold %h want fold %h", i, fold(phv_out), fold(exp_phv)); end
    end
    total++; if (n_valid !== 20 || last - first !== 19) begin bad++; $display("FAIL b2b_contiguous: got %0d outputs over span %0d want 20 over 19", n_valid, last - first); end
    total++; if (dut_cnt !== {h0 + 32'd10, m0 + 32'd10}) begin bad++; $display("FAIL b2b_counts: got %h want %h", dut_cnt, {h0 + 32'd10, m0 + 32'd10}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_idle();
      phv_valid_in  = ($urandom_range(0, 9) < 7);
      phv_in        = rand_phv();
      match_hit     = 1'($urandom_range(0, 1));
      match_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
      cfg_wr_en     = ($urandom_range(0, 9) < 3);
      cfg_wr_addr   = ($urandom_range(0, 3) == 0) ? match_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      cfg_wr_data   = rand_act();
      cfg_def_wr_en = ($urandom_range(0, 9) == 0);
      cfg_clear     = ($urandom_range(0, 49) == 0);
      tick();
      total++; if (dut_st !== exp_st) begin bad++; $display("FAIL rand_status: cycle %0d got %b want %b", i, dut_st, exp_st); end
      total++; if (action_out !== exp_act) begin bad++; $display("FAIL rand_action: cycle %0d got %h want %h", i, action_out, exp_act); end
      total++; if (phv_out !== exp_phv) begin bad++; $display("FAIL rand_phv: cycle %0d got fold %h want fold %h", i, fold(phv_out), fold(exp_phv)); end
      total++; if (dut_cnt !== exp_cnt) begin bad++; $display("FAIL rand_counts: cycle %0d got %h want %h", i, dut_cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_midflight();
    drive_idle(); cfg_clear = 1'b1;
    tick();
    drive_idle();
    repeat (3) tick();
    phv_valid_in = 1'b1; phv_in = rand_phv(); match_hit = 1'b1; match_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    tick();
    phv_in = rand_phv(); match_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    #2;
    rst = 1'b1;
    #1;
    total++; if (dut_st !== 4'b0000) begin bad++; $display("FAIL rstmid_status: got %b want 0000", dut_st); end
    total++; if (action_out !== '0) begin bad++; $display("FAIL rstmid_action: got %h want 0", action_out); end
    total++; if (phv_out !== '0) begin bad++; $display("FAIL rstmid_phv: got fold %h want 0", fold(phv_out)); end
    total++; if (dut_cnt !== 64'd0) begin bad++; $display("FAIL rstmid_counts: got %h want 0", dut_cnt); end
    model_reset();
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (dut_st !== 4'b0000) begin bad++; $display("FAIL rstmid_stale: cycle %0d got %b want 0000", i, dut_st); end
    end
    // FSM must be back in IDLE: a fresh pulse starts a clear immediately
    cfg_clear = 1'b1;
    tick();
    drive_idle();
    total++; if (dut_st !== 4'b0010) begin bad++; $display("FAIL rstmid_restart: got %b want 0010", dut_st); end
  endtask

  initial begin
    test_reset();
    test_hit_basic();
    test_default_miss();
    test_forwarding();
    test_clear();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
